alu_b_seq: RTL
==============

ALU_B_SEQ -- requirements
Module: alu_b_seq

Interface
- REQ-001 Parameter SETUP_CYC, default 2: cycles IBUS is driven before the nWALU strobe; legal range 1..15.
- REQ-002 Parameter STROBE_CYC, default 1: cycles nwalu is held low; legal range 1..15.
- REQ-003 Parameter HOLD_CYC, default 1: cycles IBUS stays driven after nwalu rises; legal range 1..15.
- REQ-004 One clock; reset is synchronous and active-low.
- REQ-005 Port clk, input, 1: the sole clock; all state updates on its rising edge.
- REQ-006 Port nreset, input, 1: synchronous active-low reset.
- REQ-007 Port nreq_uc, input, 1: microcode write request, active low, level.
- REQ-008 Port uc_data, input, 16: microcode value to load into ALU B.
- REQ-009 Port nack_uc, output, 1: microcode completion, one-cycle low pulse.
- REQ-010 Port nreq_dfp, input, 1: debug front panel write request, active low, level.
- REQ-011 Port dfp_data, input, 16: front panel value to load into ALU B.
- REQ-012 Port nack_dfp, output, 1: front panel completion, one-cycle low pulse.
- REQ-013 Port ibus_out, output, 16: value driven toward IBUS.
- REQ-014 Port nibus_oe, output, 1: IBUS drive enable, active low.
- REQ-015 Port nwalu, output, 1: ALU B register write strobe, active low; B latches on the rising edge.
- REQ-016 Port busy, output, 1: high in every state except IDLE.
- REQ-017 Port shadow, output, 16: last value strobed into ALU B; present only with ALU_B_SHADOW_EN.

Function
- REQ-018 FSM states: IDLE, SETUP, STROBE, HOLD, DONE, all registered; outputs are decoded from state only.
- REQ-019 In IDLE, with either request low, the FSM grants one requester, latches its data into ibus_out and enters SETUP.
- REQ-020 Arbitration is fixed priority: nreq_uc wins when both requests are low in the same cycle; the loser stays pending.
- REQ-021 SETUP lasts SETUP_CYC cycles: nibus_oe=0, nwalu=1.
- REQ-022 STROBE lasts STROBE_CYC cycles: nibus_oe=0, nwalu=0.
- REQ-023 HOLD lasts HOLD_CYC cycles: nibus_oe=0, nwalu=1.
- REQ-024 DONE lasts exactly 1 cycle: nibus_oe=1, nwalu=1, granted requester's nack low; then IDLE.
- REQ-025 Latency from grant edge to ack-low cycle is SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles; 5 with defaults.
- REQ-026 ibus_out holds the latched value from grant through HOLD; changes on uc_data/dfp_data mid-transaction are ignored.
- REQ-027 A requester releases its request at the edge that samples its ack low; a request still low in IDLE afterwards is a new transaction.
- REQ-028 Only one nack is ever low in a cycle; the non-granted nack stays high.
- REQ-029 Back-to-back: a pending loser is granted in the first IDLE cycle after DONE, so each transaction costs one idle cycle.
- REQ-030 Requests withdrawn after grant have no effect; the transaction completes and is acked.

Reset
- REQ-031 With nreset low at an edge: state=IDLE, nwalu=1, nibus_oe=1, nack_uc=1, nack_dfp=1, busy=0, ibus_out=16'h0000, shadow=16'h0000.
- REQ-032 Reset mid-transaction aborts it without an ack; if reset hits STROBE, nwalu rises at that edge and ALU B contents are undefined.

Configuration
- REQ-033 Macro ALU_B_SHADOW_EN: when defined, shadow exists and loads ibus_out on the STROBE->HOLD edge; when undefined, no shadow port and no shadow register.

Structure
- REQ-034 The shared package cft_pkg holds the state encoding (3-bit), the word width constant (16) and the counter width constant (4).
- REQ-035 The phase cycle counter is sub-module alu_b_seq_timer: load value, decrement, terminal-count flag.

Verification
- REQ-036 Bench case: nreq_uc low, uc_data=16'hA5C3, defaults -> nwalu low for exactly 1 cycle in cycle 3 after grant; nack_uc low in cycle 5; B=16'hA5C3.
- REQ-037 Bench case: nreq_uc and nreq_dfp low together, uc_data=16'h1234, dfp_data=16'hBEEF -> B=16'h1234 acked first; B=16'hBEEF acked 6 cycles later.
- REQ-038 Bench case: SETUP_CYC=3, STROBE_CYC=2, HOLD_CYC=4 -> nibus_oe low 9 cycles, nwalu low 2, ack 10 cycles after grant.
- REQ-039 Bench case: nreset low during STROBE -> next cycle nwalu=1, nibus_oe=1, busy=0, no ack, shadow=16'h0000.
- REQ-040 Bench case: uc_data changes 16'h0001->16'hFFFF during SETUP -> B=16'h0001.
- REQ-041 Bench case: sweep all 65536 values through the dfp port -> B and shadow (macro defined) match every value.

Source files
------------

// File: rtl/cft_pkg.sv
// rtl/cft_pkg.sv - shared state encoding and width constants for the ALU B write sequencer
package cft_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/alu_b_seq_timer.sv
// rtl/alu_b_seq_timer.sv - phase cycle counter: load, decrement, terminal-count flag
//
// Ports:
//   clk, nreset       clock, synchronous active-low reset
//   load, load_val    load the counter with load_val (phase length minus one)
//   tc                high while the count is zero, i.e. the last cycle of a phase
module alu_b_seq_timer
    import cft_pkg::*;
(
    input  logic             clk,
    input  logic             nreset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/alu_b_seq.sv
// rtl/alu_b_seq.sv - ALU B register write sequencer with fixed-priority microcode/front-panel arbitration
//
// Optional feature macro: ALU_B_SHADOW_EN (adds the shadow port and register).
//
// Ports:
//   clk, nreset            clock, synchronous active-low reset
//   nreq_uc, uc_data       microcode request (active low, level) and its value
//   nack_uc                microcode completion, one-cycle low pulse
//   nreq_dfp, dfp_data     front panel request (active low, level) and its value
//   nack_dfp               front panel completion, one-cycle low pulse
//   ibus_out, nibus_oe     value and active-low drive enable toward IBUS
//   nwalu                  ALU B write strobe, active low; B latches on its rising edge
//   busy                   high whenever the sequencer is not idle
//   shadow                 last value strobed into ALU B (ALU_B_SHADOW_EN only)
module alu_b_seq
    import cft_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 1,
    parameter int HOLD_CYC   = 1
)
(
    input  logic              clk,
    input  logic              nreset,
    input  logic              nreq_uc,
    input  logic [WORD_W-1:0] uc_data,
    output logic              nack_uc,
    input  logic              nreq_dfp,
    input  logic [WORD_W-1:0] dfp_data,
    output logic              nack_dfp,
    output logic [WORD_W-1:0] ibus_out,
    output logic              nibus_oe,
    output logic              nwalu,
    output logic              busy
`ifdef ALU_B_SHADOW_EN
    ,
    output logic [WORD_W-1:0] shadow
`endif
);

    // The timer counts down to zero, so each phase loads its length minus one.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    state_t           state;
    logic             grant_dfp;
    logic             req_any;
    logic             ld;
    logic [CNT_W-1:0] ld_val;
    logic             tc;

    assign req_any = !nreq_uc || !nreq_dfp;

    // Reload the timer on every phase entry that is followed by a timed phase.
    always_comb begin
        ld     = 1'b0;
        ld_val = SETUP_LD;
        case (state)
            ST_IDLE:   begin ld = req_any; ld_val = SETUP_LD;  end
            ST_SETUP:  begin ld = tc;      ld_val = STROBE_LD; end
            ST_STROBE: begin ld = tc;      ld_val = HOLD_LD;   end
            default:   begin ld = 1'b0;    ld_val = SETUP_LD;  end
        endcase
    end

    alu_b_seq_timer u_timer (
        .clk      (clk),
        .nreset   (nreset),
        .load     (ld),
        .load_val (ld_val),
        .tc       (tc)
    );

    // Outputs are registered alongside the state so they always match the
    // state being entered.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state     <= ST_IDLE;
            grant_dfp <= 1'b0;
            ibus_out  <= '0;
            nibus_oe  <= 1'b1;
            nwalu     <= 1'b1;
            nack_uc   <= 1'b1;
            nack_dfp  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        // Microcode wins a tie; the front panel stays pending.
                        grant_dfp <= nreq_uc;
                        ibus_out  <= !nreq_uc ? uc_data : dfp_data;
                        nibus_oe  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tc) begin
                        nwalu <= 1'b0;
                        state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (tc) begin
                        nwalu <= 1'b1;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tc) begin
                        nibus_oe <= 1'b1;
                        nack_uc  <= grant_dfp;
                        nack_dfp <= !grant_dfp;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    nack_uc  <= 1'b1;
                    nack_dfp <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    nibus_oe <= 1'b1;
                    nwalu    <= 1'b1;
                    nack_uc  <= 1'b1;
                    nack_dfp <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_B_SHADOW_EN
    // Captured on the same edge that ends the strobe, i.e. when B latches.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            shadow <= '0;
        end else if (state == ST_STROBE && tc) begin
            shadow <= ibus_out;
        end
    end
`endif

endmodule
